// File: rtl/sic_alu_lock_arbiter_pkg.sv
// Shared types and helpers for the SIC-to-ALU lock arbiter slice.
// Pool sizes live here so the interface, the picker and the top agree on widths.
package sic_pkg;

    localparam int NUM_SIC    = 4;
    localparam int NUM_ALU    = 2;
    localparam int ID_WIDTH   = 8;
    localparam int HOLD_LIMIT_DFLT = 64;

    localparam int SIC_IDX_W  = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;
    localparam int ALU_IDX_W  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
    localparam int BUSY_W     = $clog2(NUM_ALU + 1);
    // Wide enough for any practical hold limit; the counter saturates at the limit.
    localparam int HOLD_CNT_W = 16;

    typedef logic [ALU_IDX_W-1:0]  alu_idx_t;
    typedef logic [SIC_IDX_W-1:0]  sic_idx_t;
    typedef logic [ID_WIDTH-1:0]   id_t;
    typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

    typedef struct packed {
        logic      valid;
        sic_idx_t  owner;
        hold_cnt_t hold_cnt;
    } alu_owner_t;

    // id_a is older than id_b when the modular difference is negative.
    // Equal IDs return 0 so the caller's index order breaks the tie.
    function automatic logic is_older(id_t id_a, id_t id_b);
        logic signed [ID_WIDTH-1:0] diff;
        diff = signed'(id_a - id_b);
        return (diff < 0);
    endfunction

endpackage

// File: rtl/sic_alu_lock_arbiter_if.sv
// Request/grant bundle between the SIC execution sub-units and the ALU lock arbiter.
interface sic_alu_lock_arbiter_if
    import sic_pkg::*;
    ();

    logic [NUM_SIC-1:0]   req;
    id_t  [NUM_SIC-1:0]   req_issue_id;
    logic [NUM_SIC-1:0]   release_lock;

    logic [NUM_SIC-1:0]   grant;
    alu_idx_t [NUM_SIC-1:0] sic_alu_idx;
    logic [NUM_ALU-1:0]   alu_owner_valid;
    sic_idx_t [NUM_ALU-1:0] alu_owner;
    logic [BUSY_W-1:0]    busy_count;
    logic                 hold_err;

    modport master (
        output req, req_issue_id, release_lock,
        input  grant, sic_alu_idx, alu_owner_valid, alu_owner, busy_count, hold_err
    );

    modport slave (
        input  req, req_issue_id, release_lock,
        output grant, sic_alu_idx, alu_owner_valid, alu_owner, busy_count, hold_err
    );

endinterface

// File: rtl/sic_alu_lock_arbiter_oldest_pick.sv
// Selects the oldest pending SIC by issue_id; ties go to the lower SIC index.
module sic_alu_oldest_pick
    import sic_pkg::*;
(
    input  logic [NUM_SIC-1:0] pending,
    input  id_t  [NUM_SIC-1:0] ids,
    output logic               pick_valid,
    output sic_idx_t           pick_idx
);

    // Running-best reduction: a later candidate replaces the best only if strictly older.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (pending[i] && (!pick_valid || is_older(ids[i], ids[pick_idx]))) begin
                pick_valid = 1'b1;
                pick_idx   = sic_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/sic_alu_lock_arbiter.sv
// Lock arbiter sharing NUM_ALU ALUs among NUM_SIC SICs: one allocation per cycle
// to the oldest pending requester, locks held until release_lock, hold watchdog.
module sic_alu_lock_arbiter
    import sic_pkg::*;
#(
    parameter int HOLD_LIMIT = HOLD_LIMIT_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sic_alu_lock_arbiter_if.slave  bus
);

    localparam hold_cnt_t HOLD_MAX = hold_cnt_t'(HOLD_LIMIT);

    alu_owner_t [NUM_ALU-1:0] alu_q;
    alu_owner_t [NUM_ALU-1:0] alu_d;
    logic                     hold_err_q;
    logic                     hold_hit;

    logic [NUM_SIC-1:0]       held;
    alu_idx_t [NUM_SIC-1:0]   sic_alu_idx_c;
    logic [NUM_SIC-1:0]       pending;
    logic                     pick_valid;
    sic_idx_t                 pick_idx;
    logic                     free_valid;
    alu_idx_t                 free_idx;
    logic                     alloc;
    logic [BUSY_W-1:0]        busy_c;

    // Reverse map: which SICs hold a lock and on which ALU.
    always_comb begin
        held          = '0;
        sic_alu_idx_c = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            if (alu_q[a].valid) begin
                held[alu_q[a].owner]          = 1'b1;
                sic_alu_idx_c[alu_q[a].owner] = alu_idx_t'(a);
            end
        end
    end

    // A release in the same cycle withdraws the SIC from contention.
    assign pending = bus.req & ~held & ~bus.release_lock;

    sic_alu_oldest_pick u_pick (
        .pending    (pending),
        .ids        (bus.req_issue_id),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Lowest-index free ALU; an ALU being released this cycle still reads as busy.
    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int a = NUM_ALU - 1; a >= 0; a--) begin
            if (!alu_q[a].valid) begin
                free_valid = 1'b1;
                free_idx   = alu_idx_t'(a);
            end
        end
    end

    assign alloc = pick_valid && free_valid;

    // Per-ALU next state: release, watchdog count, or fresh allocation.
    always_comb begin
        alu_d    = alu_q;
        hold_hit = 1'b0;
        for (int a = 0; a < NUM_ALU; a++) begin
            if (alu_q[a].valid) begin
                if (bus.release_lock[alu_q[a].owner]) begin
                    alu_d[a] = '0;
                end else if (alu_q[a].hold_cnt != HOLD_MAX) begin
                    alu_d[a].hold_cnt = alu_q[a].hold_cnt + hold_cnt_t'(1);
                end
            end else if (alloc && (free_idx == alu_idx_t'(a))) begin
                alu_d[a].valid    = 1'b1;
                alu_d[a].owner    = pick_idx;
                alu_d[a].hold_cnt = '0;
            end
            if (alu_d[a].valid && (alu_d[a].hold_cnt == HOLD_MAX)) begin
                hold_hit = 1'b1;
            end
        end
    end

    // Owner registers; asynchronous reset drops every lock at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_err_q <= 1'b0;
        end else if (hold_hit) begin
            hold_err_q <= 1'b1;
        end
    end

    // Count of locked ALUs and per-ALU ownership outputs.
    always_comb begin
        busy_c = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            busy_c                  = busy_c + BUSY_W'(alu_q[a].valid);
            bus.alu_owner_valid[a]  = alu_q[a].valid;
            bus.alu_owner[a]        = alu_q[a].owner;
        end
    end

    assign bus.grant       = held;
    assign bus.sic_alu_idx = sic_alu_idx_c;
    assign bus.busy_count  = busy_c;
    assign bus.hold_err    = hold_err_q;

endmodule
